pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 44, SHALL set payload width (12-bit PC+4 concatenated with 32-bit instruction).
REQ-002 Parameter ZERO_BUBBLE, default 1, SHALL force out_data to 0 whenever out_valid is 0.
REQ-003 Parameter CNT_W, default 16, SHALL set stall-counter width.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 in_ready  output  1  stage can accept this cycle.
REQ-009 out_valid  output  1  out_data holds a live entry.
REQ-010 out_data  output  DATA_W  head payload, registered.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 flush  input  1  discard all held and incoming payloads (branch/jump kill).
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-014 Stage SHALL hold 0..2 entries: head slot (drives out_data) and skid slot; state EMPTY, ONE, TWO.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; it SHALL depend only on state, never combinationally on out_ready.
REQ-016 Accept SHALL occur when in_valid & in_ready & ~flush; consume SHALL occur when out_valid & out_ready.
REQ-017 EMPTY: accept -> ONE, in_data to head; out_valid 1 on the next cycle (latency 1).
REQ-018 ONE: accept & ~consume -> TWO, in_data to skid; consume & ~accept -> EMPTY; accept & consume -> ONE, in_data to head.
REQ-019 TWO: consume -> ONE, skid moves to head same edge; no consume -> TWO, both slots held unchanged.
REQ-020 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush.
REQ-021 flush SHALL win over accept and consume: next state EMPTY, both slots cleared to 0, out_valid 0.
REQ-022 With ZERO_BUBBLE=1 any slot leaving valid state SHALL be written 0; with 0 stale data MAY remain on out_data while out_valid=0.
REQ-023 stall_cnt SHALL increment by 1 each cycle out_valid & ~out_ready, saturate at all-ones, and be unaffected by flush.
REQ-024 in_valid while in_ready=0 SHALL have no effect; upstream SHALL hold the payload.

Reset
REQ-025 rst_n low SHALL immediately force state EMPTY, both slots 0, out_valid 0, out_data 0, stall_cnt 0, in_ready 1.
REQ-026 Reset asserted mid-transfer SHALL abandon held entries; first accept after release behaves as from EMPTY.
REQ-027 Deassertion SHALL be synchronised externally; the block SHALL not act on the release edge itself.

Structure
REQ-028 Package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and default widths PC_W=12, INST_W=32.
REQ-029 One sub-module pipe_slot SHALL implement a DATA_W register with load, clear and async reset; instantiated twice (head, skid).
REQ-030 Control FSM and counter SHALL live in pipe_stage.

Verification
REQ-031 Reset then in_valid=1, in_data=0x00C_00000013, out_ready=1 -> next cycle out_valid=1, out_data=0x00C_00000013, in_ready=1.
REQ-032 Send A=0x1,B=0x2 back-to-back with out_ready=0 -> state TWO, in_ready=0, out_data=0x1; drive C=0x3 -> ignored; out_ready=1 two cycles -> outputs 0x1 then 0x2, C never appears.
REQ-033 In TWO assert flush with in_valid=1 -> next cycle out_valid=0, out_data=0, in_ready=1; incoming payload dropped.
REQ-034 out_ready=0 with head valid for 70000 cycles, CNT_W=16 -> stall_cnt saturates at 0xFFFF.
REQ-035 Continuous in_valid=1, out_ready=1, data 1..100 -> one output per cycle, order 1..100, state never TWO.
REQ-036 rst_n low for one cycle while in TWO -> outputs all 0 immediately, then normal operation from EMPTY.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register stage: state encoding and
// default payload field widths.
package pipe_pkg;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned INST_W = 32;

  // Occupancy of the stage: no entry, head only, head plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the stage, with synchronous clear and load.
module pipe_slot #(
  parameter int unsigned DATA_W = 44
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Clear beats load so a kill always leaves the slot zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline register with flush and a saturating
// back-pressure cycle counter. in_ready is a pure function of occupancy.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = PC_W + INST_W,
  parameter bit          ZERO_BUBBLE = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state, state_n;
  logic              accept, consume;
  logic              head_load, head_clr, skid_load, skid_clr;
  logic [DATA_W-1:0] head_d, head_q, skid_q;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;

  // The head refills from the skid when draining out of TWO, otherwise from upstream.
  assign head_d = (state == TWO) ? skid_q : in_data;

  // Masking keeps out_data at zero while invalid even if the head holds stale data.
  assign out_data = (ZERO_BUBBLE && !out_valid) ? '0 : head_q;

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next occupancy and slot load/clear strobes; flush overrides everything.
  always_comb begin
    state_n   = state;
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      state_n  = EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            state_n   = ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_load = 1'b1;
            state_n   = TWO;
          end else if (consume && !accept) begin
            head_clr = ZERO_BUBBLE;
            state_n  = EMPTY;
          end else if (accept && consume) begin
            head_load = 1'b1;
          end
        end
        TWO: begin
          if (consume) begin
            head_load = 1'b1;
            skid_clr  = ZERO_BUBBLE;
            state_n   = ONE;
          end
        end
        default: begin
          state_n  = EMPTY;
          head_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Count cycles a live head is held back by downstream; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  pipe_slot #(.DATA_W(DATA_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_load),
    .clear (head_clr),
    .d     (head_d),
    .q     (head_q)
  );

  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a queue models the two-entry FIFO and a
// saturating counter models stall_cnt.
module tb_pipe_stage;

  localparam int unsigned DATA_W = 44;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;

  logic [DATA_W-1:0] sb[$];
  logic [CNT_W-1:0]  exp_stall;
  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage #(
    .DATA_W      (DATA_W),
    .ZERO_BUBBLE (1'b1),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle: check current outputs against the model, step the model
  // with the pre-edge occupancy, then advance past the clock edge.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl, input bit chk_stall);
    logic [DATA_W-1:0] head;
    bit acc, cons;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    head = (sb.size() > 0) ? sb[0] : '0;
    check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() > 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    check("out_data", {20'd0, out_data}, {20'd0, head});
    if (chk_stall) check("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall});
    acc  = iv && (sb.size() < 2) && !fl;
    cons = (sb.size() > 0) && ordy;
    if (sb.size() > 0 && !ordy && exp_stall != '1) exp_stall++;
    if (fl) begin
      sb.delete();
    end else begin
      if (cons) begin
        check("consumed", {20'd0, out_data}, {20'd0, sb.pop_front()});
      end
      if (acc) sb.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    exp_stall = '0;
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {20'd0, out_data}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First transfer from EMPTY: visible the next cycle.
    cycle(1'b1, 44'h00C_00000013, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle_check();

    // Back-pressure fills both slots; third payload is refused.
    cycle(1'b1, 44'h1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 44'h2, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 44'h3, 1'b0, 1'b0, 1'b1);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_head", {20'd0, out_data}, 64'h1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle_check();

    // Flush from TWO with an incoming payload.
    cycle(1'b1, 44'hA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 44'hB, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 44'hC, 1'b1, 1'b1, 1'b1);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_data", {20'd0, out_data}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    idle_check();

    // Streaming at full rate: the stage never fills.
    for (int i = 1; i <= 100; i++) begin
      cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b1);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
    end
    idle_check();
    idle_check();

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), {12'($urandom), 32'($urandom)},
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b1);
    end
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
    idle_check();

    // Asynchronous reset while holding two entries.
    cycle(1'b1, 44'h111, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 44'h222, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_data", {20'd0, out_data}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_stall", {48'd0, stall_cnt}, 64'd0);
    sb.delete();
    exp_stall = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 44'h333, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle_check();

    // Hold a valid head for long enough to saturate the counter.
    cycle(1'b1, 44'h777, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0, (i % 4096) == 0);
    end
    check("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
    check("stall_after_flush", {48'd0, stall_cnt}, 64'hFFFF);
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
